// File: rtl/aux_lt_pkg.sv
// Shared types and encodings for the link-training AUX request path.
package aux_lt_pkg;

   localparam int AUX_MAX_LEN = 16;
   localparam int AUX_IDX_W   = $clog2(AUX_MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SEND_HDR,
      ST_SEND_DATA,
      ST_WAIT_REPLY,
      ST_RX_DATA,
      ST_DONE,
      ST_FAIL
   } state_e;

   localparam logic [1:0] CMD_NATIVE_WR = 2'b00;
   localparam logic [1:0] CMD_NATIVE_RD = 2'b01;

   localparam logic [3:0] AUX_REQ_WR = 4'b1000;
   localparam logic [3:0] AUX_REQ_RD = 4'b1001;

   localparam logic [1:0] REPLY_ACK   = 2'b00;
   localparam logic [1:0] REPLY_NACK  = 2'b01;
   localparam logic [1:0] REPLY_DEFER = 2'b10;

endpackage

// File: rtl/aux_req_buffer.sv
// Write-payload store: one synchronous write port, one combinational read port.
module aux_req_buffer
   import aux_lt_pkg::*;
(
   input  logic                 clk,
   input  logic                 we,
   input  logic [AUX_IDX_W-1:0] waddr,
   input  logic [7:0]           wdata,
   input  logic [AUX_IDX_W-1:0] raddr,
   output logic [7:0]           rdata
);

   // Contents are don't-care after reset, so no reset term.
   logic [AUX_MAX_LEN-1:0][7:0] mem;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/aux_lt_req_ctrl.sv
// Frames native DPCD requests from the CR/EQ FSMs onto AUX and parses the
// reply, retrying on DEFER or reply timeout.
module aux_lt_req_ctrl
   import aux_lt_pkg::*;
#(
   parameter int MAX_RETRY     = 7,
   parameter int REPLY_TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cr_transaction_vld,
   input  logic        eq_transaction_vld,
   input  logic [1:0]  cr_cmd,
   input  logic [1:0]  eq_cmd,
   input  logic [19:0] cr_address,
   input  logic [19:0] eq_address,
   input  logic [7:0]  cr_len,
   input  logic [7:0]  eq_len,
   input  logic [7:0]  cr_data,
   input  logic [7:0]  eq_data,
   output logic        aux_tx_vld,
   output logic [7:0]  aux_tx_byte,
   output logic        aux_tx_last,
   input  logic        aux_tx_ready,
   input  logic        aux_rx_vld,
   input  logic [7:0]  aux_rx_byte,
   input  logic        aux_rx_last,
   output logic        ctrl_ack_flag,
   output logic        ctrl_native_failed,
   output logic [7:0]  ctrl_rd_data,
   output logic        ctrl_rd_data_vld,
   output logic        ctrl_busy
);

   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int TW = $clog2(REPLY_TIMEOUT + 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TMO_LIM   = TW'(REPLY_TIMEOUT);

   state_e               state_q, state_d;
   logic                 is_rd_q, is_rd_d;
   logic                 src_eq_q, src_eq_d;
   logic [19:0]          addr_q, addr_d;
   logic [7:0]           len_q, len_d;
   logic [AUX_IDX_W-1:0] idx_q, idx_d;
   logic [1:0]           hdr_q, hdr_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic                 rd_vld_q, rd_vld_d;

   logic                 buf_we;
   logic [AUX_IDX_W-1:0] buf_waddr;
   logic [7:0]           buf_wdata, buf_rdata;

   logic                 new_vld;
   logic [1:0]           new_cmd;
   logic [19:0]          new_addr;
   logic [7:0]           new_len, new_data;
   logic                 req_vld;
   logic [7:0]           req_data;
   logic                 tx_fire, data_last, retry_req;

   // CR wins a same-cycle collision; the losing EQ request is simply dropped.
   assign new_vld  = cr_transaction_vld | eq_transaction_vld;
   assign new_cmd  = cr_transaction_vld ? cr_cmd     : eq_cmd;
   assign new_addr = cr_transaction_vld ? cr_address : eq_address;
   assign new_len  = cr_transaction_vld ? cr_len     : eq_len;
   assign new_data = cr_transaction_vld ? cr_data    : eq_data;
   assign req_vld  = src_eq_q ? eq_transaction_vld : cr_transaction_vld;
   assign req_data = src_eq_q ? eq_data : cr_data;

   assign tx_fire   = aux_tx_vld & aux_tx_ready;
   assign data_last = (idx_q == len_q[AUX_IDX_W-1:0]);

   always_comb begin
      aux_tx_vld  = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA);
      aux_tx_last = ((state_q == ST_SEND_HDR) && (hdr_q == 2'd3) && is_rd_q) ||
                    ((state_q == ST_SEND_DATA) && data_last);
      aux_tx_byte = '0;
      if (state_q == ST_SEND_HDR) begin
         case (hdr_q)
            2'd0:    aux_tx_byte = {(is_rd_q ? AUX_REQ_RD : AUX_REQ_WR), addr_q[19:16]};
            2'd1:    aux_tx_byte = addr_q[15:8];
            2'd2:    aux_tx_byte = addr_q[7:0];
            default: aux_tx_byte = len_q;
         endcase
      end else if (state_q == ST_SEND_DATA) begin
         aux_tx_byte = buf_rdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_rd_d   = is_rd_q;
      src_eq_d  = src_eq_q;
      addr_d    = addr_q;
      len_d     = len_q;
      idx_d     = idx_q;
      hdr_d     = hdr_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      rd_data_d = rd_data_q;
      rd_vld_d  = 1'b0;
      buf_we    = 1'b0;
      buf_waddr = idx_q;
      buf_wdata = req_data;
      retry_req = 1'b0;
      case (state_q)
         ST_IDLE: if (new_vld) begin
            src_eq_d  = !cr_transaction_vld;
            is_rd_d   = (new_cmd == CMD_NATIVE_RD);
            addr_d    = new_addr;
            len_d     = new_len;
            idx_d     = AUX_IDX_W'(1);
            hdr_d     = 2'd0;
            buf_we    = 1'b1;
            buf_waddr = '0;
            buf_wdata = new_data;
            if (new_cmd[1] || int'(new_len) >= AUX_MAX_LEN) state_d = ST_FAIL;
            else if (new_cmd == CMD_NATIVE_RD || new_len == 8'd0) state_d = ST_SEND_HDR;
            else state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (req_vld) begin
               buf_we = 1'b1;
               if (data_last) state_d = ST_SEND_HDR;
               else idx_d = idx_q + 1'b1;
            end else begin
               state_d = ST_FAIL;
            end
         end
         ST_SEND_HDR: if (tx_fire) begin
            if (hdr_q == 2'd3) begin
               idx_d   = '0;
               tmo_d   = '0;
               state_d = is_rd_q ? ST_WAIT_REPLY : ST_SEND_DATA;
            end else begin
               hdr_d = hdr_q + 1'b1;
            end
         end
         ST_SEND_DATA: if (tx_fire) begin
            if (data_last) begin
               tmo_d   = '0;
               state_d = ST_WAIT_REPLY;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WAIT_REPLY: begin
            // A reply byte landing on the timeout cycle takes precedence.
            if (aux_rx_vld) begin
               case (aux_rx_byte[5:4])
                  REPLY_ACK: begin
                     if (!is_rd_q) state_d = aux_rx_last ? ST_DONE : ST_FAIL;
                     else if (aux_rx_last) state_d = ST_FAIL;
                     else begin
                        idx_d   = '0;
                        state_d = ST_RX_DATA;
                     end
                  end
                  REPLY_DEFER: retry_req = 1'b1;
                  default:     state_d = ST_FAIL;
               endcase
            end else if (tmo_q == TMO_LIM) begin
               retry_req = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_RX_DATA: if (aux_rx_vld) begin
            rd_vld_d  = 1'b1;
            rd_data_d = aux_rx_byte;
            if (aux_rx_last) state_d = data_last ? ST_DONE : ST_FAIL;
            else if (data_last) state_d = ST_FAIL;
            else idx_d = idx_q + 1'b1;
         end
         ST_DONE, ST_FAIL: begin
            retry_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (retry_req) begin
         if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            hdr_d   = 2'd0;
            state_d = ST_SEND_HDR;
         end else begin
            state_d = ST_FAIL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         is_rd_q   <= 1'b0;
         src_eq_q  <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         hdr_q     <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_rd_q   <= is_rd_d;
         src_eq_q  <= src_eq_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         hdr_q     <= hdr_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   aux_req_buffer u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (buf_wdata),
      .raddr (idx_q),
      .rdata (buf_rdata)
   );

   assign ctrl_ack_flag      = (state_q == ST_DONE);
   assign ctrl_native_failed = (state_q == ST_FAIL);
   assign ctrl_rd_data       = rd_data_q;
   assign ctrl_rd_data_vld   = rd_vld_q;
   assign ctrl_busy          = (state_q != ST_IDLE);

endmodule
